credit_sink: RTL and testbench

//  Receive end of a credit-based link; the transmit end is a credit/rate-limited sender.
//  - Buffers words pushed by the sender without backpressure.
//  - Presents buffered words to a valid/ready consumer.
//  - Returns one credit pulse per freed entry; the full depth is advertised after reset.
//  - Detects sender protocol violations (push with no credit) as a sticky error.

---
 rtl/credit_sink.sv | 165 ++++++++++++++++
 tb/tb_credit_sink.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sink.sv
// credit_sink: receive end of a credit-based link.
// Words pushed by the sender are buffered without backpressure. They are handed
// to a valid/ready consumer in order. Every freed entry returns one credit pulse.
// After reset the full depth of credits is advertised. A push that arrives while
// the buffer is full is dropped and sets a sticky error flag.
module credit_sink #(
    parameter int W  = 32,
    parameter int N  = 16,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          credit_vld,
    output logic [CW-1:0] occupancy,
    output logic          init_done,
    output logic          overflow_r
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Storage and pointers
    logic [W-1:0]  mem [N];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;

    // Credit return and initialisation tracking
    logic [CW-1:0] credit_pend_q, credit_pend_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic          credit_vld_q, credit_vld_d;
    logic          init_done_q, init_done_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;

    logic full;
    logic push;
    logic pop;
    logic issue;

    assign full  = (occ_q == CW'(N));
    assign push  = in_valid & ~full;
    assign pop   = out_valid & out_ready;
    assign issue = (credit_pend_q != '0);

    assign out_valid  = (occ_q != '0);
    assign out_data   = mem[rd_ptr_q];
    assign occupancy  = occ_q;
    assign credit_vld = credit_vld_q;
    assign init_done  = init_done_q;
    assign overflow_r = overflow_q;

    // Write accepted pushes into the buffer at the write pointer.
    // NOTE: the storage array has no reset; its contents are only read behind
    // occupancy, so resetting it would cost a reset net per bit for no benefit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // Next-state logic for the pointers, occupancy, credit backlog and flags.
    // NOTE: every *_d gets a default at the top, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        credit_pend_d = credit_pend_q;
        credit_vld_d  = issue;
        overflow_d    = overflow_q | (in_valid & full);

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(N - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(N - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        // A push is never accepted when full, so occupancy stays within 0..N.
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // One credit leaves per cycle while a backlog exists; each pop adds one.
        case ({issue, pop})
            2'b10:   credit_pend_d = credit_pend_q - 1'b1;
            2'b01:   credit_pend_d = credit_pend_q + 1'b1;
            default: credit_pend_d = credit_pend_q;
        endcase
    end

    // Init FSM: counts the first N issued credits, then parks in RUN.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        init_done_d = init_done_q;

        case (state_q)
            ST_INIT: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == CW'(N - 1)) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            credit_pend_q <= CW'(N);
            issue_cnt_q   <= '0;
            credit_vld_q  <= 1'b0;
            init_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
            state_q       <= ST_INIT;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            credit_pend_q <= credit_pend_d;
            issue_cnt_q   <= issue_cnt_d;
            credit_vld_q  <= credit_vld_d;
            init_done_q   <= init_done_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
        end
    end

    // Credit conservation: buffered words plus the unreturned backlog can never
    // exceed the advertised depth. Credits still held by the sender make up the rest.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ((CW+1)'(occ_q) + (CW+1)'(credit_pend_q) <= (CW+1)'(N))
            else $error("credit_sink: occupancy plus pending credits exceeds depth");
        end
    end

endmodule

// File: tb/tb_credit_sink.sv
// Directed bench for credit_sink. The bench keeps its own expected occupancy and
// a queue of expected words. A word is queued when the sender pushes it into a
// non-full buffer. It is checked against the DUT when the consumer accepts it.
module tb_credit_sink;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          credit_vld;
    logic [CW-1:0] occupancy;
    logic          init_done;
    logic          overflow_r;

    credit_sink #(.W(W), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .credit_vld (credit_vld),
        .occupancy  (occupancy),
        .init_done  (init_done),
        .overflow_r (overflow_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] sb [$];
    int occ_m      = 0;
    int pops       = 0;
    int cyc        = 0;
    int cred_cnt   = 0;
    int cred_first = -1;
    int cred_last  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_credit_stats();
        cred_cnt   = 0;
        cred_first = -1;
        cred_last  = -1;
        pops       = 0;
    endtask

    // One clock cycle. Inputs for this cycle are already driven, and the DUT
    // outputs reflect the state left by the previous edge.
    task automatic cycle();
        logic         do_push;
        logic         do_pop;
        logic [W-1:0] exp_word;
        check("occupancy", 32'(occupancy), 32'(occ_m));
        check("out_valid", 32'(out_valid), 32'(occ_m != 0));
        do_push = in_valid && (occ_m != N);
        do_pop  = (occ_m != 0) && out_ready;
        if (do_pop) begin
            exp_word = sb.pop_front();
            check("out_data", out_data, exp_word);
            pops++;
        end
        if (do_push) sb.push_back(in_data);
        occ_m = occ_m + int'(do_push) - int'(do_pop);
        if (credit_vld === 1'b1) begin
            if (cred_cnt == 0) cred_first = cyc;
            cred_last = cyc;
            cred_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Apply one reset edge, verify the reset state and release.
    task automatic apply_reset(input string tag);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        sb.delete();
        occ_m = 0;
        check({tag, "_occupancy"},  32'(occupancy),  32'd0);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_credit_vld"}, 32'(credit_vld), 32'd0);
        check({tag, "_init_done"},  32'(init_done),  32'd0);
        check({tag, "_overflow"},   32'(overflow_r), 32'd0);
        rst_n = 1'b1;
        clear_credit_stats();
    endtask

    // Idle after reset: the initial credit train is N pulses long and contiguous.
    task automatic check_initial_train(input string tag);
        int start;
        start = cyc;
        for (int i = 0; i < 22; i++) begin
            if (i == 15) check({tag, "_init_done_before"}, 32'(init_done), 32'd0);
            if (i == 16) check({tag, "_init_done_after"},  32'(init_done), 32'd1);
            cycle();
        end
        check({tag, "_credit_count"}, 32'(cred_cnt), 32'(N));
        check({tag, "_credit_first"}, 32'(cred_first), 32'(start + 1));
        check({tag, "_credit_contig"}, 32'(cred_last - cred_first + 1), 32'(N));
        check({tag, "_init_done_end"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // 1) Reset, then the idle initial credit train.
        apply_reset("t1_reset");
        check_initial_train("t1");

        // 2) Four back-to-back pushes with the consumer always ready.
        clear_credit_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 4);
            in_data  = 32'hA5A5_0001 + 32'(i);
            if (i == 1) check("t2_latency_valid", 32'(out_valid), 32'd1);
            if (i == 1) check("t2_first_word", out_data, 32'hA5A5_0001);
            cycle();
        end
        in_valid = 1'b0;
        check("t2_pops", 32'(pops), 32'd4);
        check("t2_credit_count", 32'(cred_cnt), 32'd4);

        // 3) Fill the buffer with the consumer stalled, then push once more.
        clear_credit_stats();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB000_0000 + 32'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("t3_full_occupancy", 32'(occupancy), 32'(N));
        check("t3_no_overflow_yet", 32'(overflow_r), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        cycle();
        in_valid = 1'b0;
        check("t3_overflow_set", 32'(overflow_r), 32'd1);
        check("t3_head_unchanged", out_data, 32'hB000_0000);
        check("t3_occupancy_held", 32'(occupancy), 32'(N));
        for (int i = 0; i < 4; i++) cycle();
        check("t3_overflow_sticky", 32'(overflow_r), 32'd1);
        check("t3_no_credits", 32'(cred_cnt), 32'd0);

        // 4) Consumer ready while the sender pushes every cycle; pointers wrap.
        clear_credit_stats();
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hE000_0000 + 32'(i);
            if (i == 6)  check("t4_steady_occ_a", 32'(occupancy), 32'(N - 1));
            if (i == 20) check("t4_steady_occ_b", 32'(occupancy), 32'(N - 1));
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 24; i++) cycle();
        check("t4_drained", 32'(occupancy), 32'd0);
        check("t4_pops", 32'(pops), 32'(N + 23));
        check("t4_credits_match_pops", 32'(cred_cnt), 32'(pops));

        // 6) Reset while seven words are buffered and overflow is latched.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h6000_0000 + 32'(i);
            cycle();
        end
        in_valid = 1'b0;
        check("t6_occupancy_7", 32'(occupancy), 32'd7);
        check("t6_overflow_before", 32'(overflow_r), 32'd1);
        apply_reset("t6_reset");
        check_initial_train("t6");

        // 5) Three words pushed and popped while the initial train is running.
        apply_reset("t5_reset");
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_valid = (i >= 3) && (i < 6);
            in_data  = 32'hC000_0000 + 32'(i);
            cycle();
        end
        in_valid = 1'b0;
        check("t5_pops", 32'(pops), 32'd3);
        check("t5_credit_count", 32'(cred_cnt), 32'(N + 3));
        check("t5_credit_contig", 32'(cred_last - cred_first + 1), 32'(N + 3));
        check("t5_init_done", 32'(init_done), 32'd1);
        check("t5_no_overflow", 32'(overflow_r), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
